// File: rtl/serial_adder_ctrl_if.sv
// Operand/result bundle for the bit-serial add/subtract sequencer.
// master drives the request side; slave is the sequencer.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  modport master (
    output start, a, b, sub,
    input  busy, done, result, cout, overflow
  );

  modport slave (
    input  start, a, b, sub,
    output busy, done, result, cout, overflow
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell, LSB first.
// SERIAL_ADD_SUB_EN enables subtraction (a + ~b + 1); otherwise add-only.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  serial_adder_ctrl_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] acc_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             cmsb_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             ovf_q;

  logic             b_eff;
  logic             s_bit;
  logic             c_bit;
  logic             sub_in;

`ifdef SERIAL_ADD_SUB_EN
  logic sub_q;
  assign sub_in = bus.sub;
  assign b_eff  = b_sh_q[0] ^ sub_q;
`else
  logic unused_sub;
  assign unused_sub = bus.sub;
  assign sub_in     = 1'b0;
  assign b_eff      = b_sh_q[0];
`endif

  assign s_bit = a_sh_q[0] ^ b_eff ^ carry_q;
  assign c_bit = (a_sh_q[0] & b_eff)
               | (a_sh_q[0] & carry_q)
               | (b_eff & carry_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cmsb_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q <= RUN;
            a_sh_q  <= bus.a;
            b_sh_q  <= bus.b;
            acc_q   <= '0;
            cnt_q   <= '0;
            carry_q <= sub_in;
            cmsb_q  <= 1'b0;
            busy_q  <= 1'b1;
`ifdef SERIAL_ADD_SUB_EN
            sub_q   <= sub_in;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          acc_q   <= {s_bit, acc_q[WIDTH-1:1]};
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          carry_q <= c_bit;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CNT_PRE) begin
            cmsb_q <= c_bit;
          end
          // Outputs are registered on the edge that retires the MSB
          if (cnt_q == CNT_LAST) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= {s_bit, acc_q[WIDTH-1:1]};
            cout_q   <= c_bit;
            ovf_q    <= cmsb_q ^ c_bit;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: arithmetic reference model plus directed runs.
// Expected subtract results follow the SERIAL_ADD_SUB_EN build setting.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  bit   armed;
  int   checks;
  int   failures;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: phase counts edges since acceptance
  int         m_phase = 0;
  logic [7:0] m_res = '0;
  logic       m_cout = 1'b0;
  logic       m_ovf = 1'b0;
  logic [7:0] p_res = '0;
  logic       p_cout = 1'b0;
  logic       p_ovf = 1'b0;
  logic [8:0] full;
  logic       eff_sub;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_res   = '0;
      m_cout  = 1'b0;
      m_ovf   = 1'b0;
    end else if (m_phase == 0 || m_phase == W + 1) begin
      if (bus.start) begin
`ifdef SERIAL_ADD_SUB_EN
        eff_sub = bus.sub;
`else
        eff_sub = 1'b0;
`endif
        if (eff_sub)
          full = {1'b0, bus.a} + {1'b0, ~bus.b} + 9'd1;
        else
          full = {1'b0, bus.a} + {1'b0, bus.b};
        p_res  = full[7:0];
        p_cout = full[8];
        if (eff_sub)
          p_ovf = (bus.a[7] != bus.b[7]) && (full[7] != bus.a[7]);
        else
          p_ovf = (bus.a[7] == bus.b[7]) && (full[7] != bus.a[7]);
        m_phase = 1;
      end else begin
        m_phase = 0;
      end
    end else begin
      m_phase++;
      if (m_phase == W + 1) begin
        m_res  = p_res;
        m_cout = p_cout;
        m_ovf  = p_ovf;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("cmp_busy", 32'(bus.busy), 32'(m_phase >= 1 && m_phase <= W));
      chk("cmp_done", 32'(bus.done), 32'(m_phase == W + 1));
      chk("cmp_result", 32'(bus.result), 32'(m_res));
      chk("cmp_cout", 32'(bus.cout), 32'(m_cout));
      chk("cmp_ovf", 32'(bus.overflow), 32'(m_ovf));
      chk("cmp_exclusive", 32'(bus.busy & bus.done), 32'd0);
    end
  end

  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                        input logic isub, input logic [7:0] er,
                        input logic ec, input logic eo, input string nm);
    int busy_n;
    int done_at;
    int done_n;
    busy_n  = 0;
    done_at = 0;
    done_n  = 0;
    @(negedge clk);
    bus.a     = ia;
    bus.b     = ib;
    bus.sub   = isub;
    bus.start = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (done_at == 0) done_at = i;
        chk({nm, "_result"}, 32'(bus.result), 32'(er));
        chk({nm, "_cout"}, 32'(bus.cout), 32'(ec));
        chk({nm, "_ovf"}, 32'(bus.overflow), 32'(eo));
      end
    end
    chk({nm, "_busy_cycles"}, 32'(busy_n), 32'd8);
    chk({nm, "_done_cycle"}, 32'(done_at), 32'd9);
    chk({nm, "_done_count"}, 32'(done_n), 32'd1);
  endtask

  initial begin
    int done_n;
    int busy_n;
    int dc[$];
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.sub   = 1'b0;
    @(posedge clk);
    armed = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    #2 rst_n = 1'b1;

    run_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, "add_35_4a");
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01");
`ifdef SERIAL_ADD_SUB_EN
    run_op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, "sub_10_20");
    run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01");
`else
    run_op(8'h10, 8'h20, 1'b1, 8'h30, 1'b0, 1'b0, "sub_10_20");
    run_op(8'h80, 8'h01, 1'b1, 8'h81, 1'b0, 1'b0, "sub_80_01");
`endif

    // start while busy must be ignored
    @(negedge clk);
    bus.a = 8'h35; bus.b = 8'h4A; bus.sub = 1'b0; bus.start = 1'b1;
    done_n = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (i == 4) begin
        bus.a = 8'h01; bus.b = 8'h01; bus.start = 1'b1;
      end
      if (bus.done) begin
        done_n++;
        chk("ign_done_cycle", 32'(i), 32'd9);
        chk("ign_result", 32'(bus.result), 32'h7F);
      end
    end
    chk("ign_done_count", 32'(done_n), 32'd1);

    // start held high: back-to-back results
    @(negedge clk);
    bus.a = 8'h35; bus.b = 8'h4A; bus.start = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (bus.done) dc.push_back(i);
      if (i == 27) bus.start = 1'b0;
    end
    chk("b2b_count", 32'(dc.size()), 32'd3);
    if (dc.size() == 3) begin
      chk("b2b_first", 32'(dc[0]), 32'd9);
      chk("b2b_second", 32'(dc[1]), 32'd18);
      chk("b2b_third", 32'(dc[2]), 32'd27);
    end

    // asynchronous reset mid-run
    @(negedge clk);
    bus.a = 8'h12; bus.b = 8'h34; bus.start = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_result", 32'(bus.result), 32'd0);
    chk("arst_cout", 32'(bus.cout), 32'd0);
    chk("arst_ovf", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    done_n = 0;
    busy_n = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (bus.done) done_n++;
      if (bus.busy) busy_n++;
    end
    chk("arst_no_done", 32'(done_n), 32'd0);
    chk("arst_no_busy", 32'(busy_n), 32'd0);
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
